pc_sequencer: RTL and testbench

Program-counter sequencer for the 8-bit core. Owns the PC register, runs the instruction-fetch handshake, evaluates branch conditions against ALU status flags and drives the 2-bit branch-select code for the next-PC selector. Sits between the instruction memory port and the decode/datapath stage; every PC change in the core goes through this block.

---
 rtl/pc_sequencer_pkg.sv | 44 ++++
 rtl/pc_next_sel.sv | 25 ++
 rtl/pc_sequencer.sv | 101 ++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: branch-select codes,
// branch condition codes, sequencer states and the condition evaluator.
package pc_sequencer_pkg;

   localparam logic [7:0] RESET_VEC_DEFAULT = 8'h00;

   localparam logic [1:0] BS_SEQ = 2'b00;
   localparam logic [1:0] BS_BR  = 2'b01;
   localparam logic [1:0] BS_JMP = 2'b10;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'b000,
      COND_Z      = 3'b001,
      COND_NZ     = 3'b010,
      COND_N      = 3'b011,
      COND_NN     = 3'b100,
      COND_C      = 3'b101,
      COND_V      = 3'b110,
      COND_NEVER  = 3'b111
   } br_cond_t;

   typedef enum logic [1:0] {
      FETCH  = 2'b00,
      DECODE = 2'b01,
      UPDATE = 2'b10,
      HALTED = 2'b11
   } state_t;

   function automatic logic cond_true(input logic [2:0] cond,
                                      input logic z, input logic n,
                                      input logic c, input logic v);
      case (br_cond_t'(cond))
         COND_ALWAYS: return 1'b1;
         COND_Z:      return z;
         COND_NZ:     return !z;
         COND_N:      return n;
         COND_NN:     return !n;
         COND_C:      return c;
         COND_V:      return v;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selector: picks sequential, jump or branch target from the
// registered branch-select code.
module pc_next_sel
   import pc_sequencer_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic [1:0]        bs_sel,
   input  logic [ADDR_W-1:0] pc_inc,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] next_pc
);

   always_comb begin
      // NOTE: default assignment first so no path leaves next_pc unassigned (no latch).
      next_pc = pc_inc;
      case (bs_sel)
         BS_JMP:  next_pc = jmp_target;
         BS_BR:   next_pc = br_target;
         default: ;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, branch evaluation and PC update
// in a FETCH -> DECODE -> UPDATE loop, with a terminal HALTED state.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              instr_req,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic              instr_ack,
   input  logic              dec_valid,
   input  logic              jmp_en,
   input  logic              br_en,
   input  logic [2:0]        br_cond,
   input  logic [7:0]        br_offset,
   input  logic [ADDR_W-1:0] raa,
   input  logic              flag_z,
   input  logic              flag_n,
   input  logic              flag_c,
   input  logic              flag_v,
   input  logic              halt,
   output logic [1:0]        bs_sel,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   state_t            state;
   logic [ADDR_W-1:0] raa_q;
   logic [7:0]        off_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] next_pc;

   assign pc_inc     = pc + ADDR_W'(1);
   assign br_target  = pc_inc + ADDR_W'(signed'(off_q));
   assign instr_addr = pc;

   pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
      .bs_sel     (bs_sel),
      .pc_inc     (pc_inc),
      .jmp_target (raa_q),
      .br_target  (br_target),
      .next_pc    (next_pc)
   );

   // Flags are consumed on the dec_valid cycle, so the branch decision itself
   // is what gets registered (as bs_sel) rather than the raw flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FETCH;
         pc        <= RESET_VEC;
         bs_sel    <= BS_SEQ;
         instr_req <= 1'b0;
         halted    <= 1'b0;
         raa_q     <= '0;
         off_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         case (state)
            FETCH: begin
               if (instr_req && instr_ack) begin
                  instr_req <= 1'b0;
                  state     <= DECODE;
               end else begin
                  instr_req <= 1'b1;
               end
            end
            DECODE: begin
               if (dec_valid) begin
                  raa_q <= raa;
                  off_q <= br_offset;
                  if (halt) begin
                     bs_sel <= BS_SEQ;
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     if (jmp_en)
                        bs_sel <= BS_JMP;
                     else if (br_en && cond_true(br_cond, flag_z, flag_n, flag_c, flag_v))
                        bs_sel <= BS_BR;
                     else
                        bs_sel <= BS_SEQ;
                     state <= UPDATE;
                  end
               end
            end
            UPDATE: begin
               pc        <= next_pc;
               instr_req <= 1'b1;
               state     <= FETCH;
            end
            HALTED: ;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: scoreboard of expected PC/bs_sel per
// instruction, checked with immediate assertions.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_req;
   logic [7:0] instr_addr;
   logic       instr_ack;
   logic       dec_valid;
   logic       jmp_en;
   logic       br_en;
   logic [2:0] br_cond;
   logic [7:0] br_offset;
   logic [7:0] raa;
   logic       flag_z, flag_n, flag_c, flag_v;
   logic       halt;
   logic [1:0] bs_sel;
   logic [7:0] pc;
   logic       halted;

   typedef struct packed {
      logic [7:0] pc;
      logic [1:0] bs;
      logic       hlt;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model_pc;
   int         tests = 0;
   int         fails = 0;

   pc_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_req  (instr_req),
      .instr_addr (instr_addr),
      .instr_ack  (instr_ack),
      .dec_valid  (dec_valid),
      .jmp_en     (jmp_en),
      .br_en      (br_en),
      .br_cond    (br_cond),
      .br_offset  (br_offset),
      .raa        (raa),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .flag_c     (flag_c),
      .flag_v     (flag_v),
      .halt       (halt),
      .bs_sel     (bs_sel),
      .pc         (pc),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // flags packed as {z, n, c, v}
   function automatic logic cond_ok(input logic [2:0] c, input logic [3:0] f);
      case (c)
         3'd0:    return 1'b1;
         3'd1:    return f[3];
         3'd2:    return !f[3];
         3'd3:    return f[2];
         3'd4:    return !f[2];
         3'd5:    return f[1];
         3'd6:    return f[0];
         default: return 1'b0;
      endcase
   endfunction

   task automatic clear_ctrl();
      dec_valid = 1'b0; jmp_en = 1'b0; br_en = 1'b0; br_cond = 3'd0;
      br_offset = 8'h00; raa = 8'h00; halt = 1'b0;
      {flag_z, flag_n, flag_c, flag_v} = 4'b0000;
   endtask

   task automatic run_instr(input string tag, input logic j, input logic b,
                            input logic [2:0] c, input logic [7:0] off,
                            input logic [7:0] r, input logic [3:0] f,
                            input logic h, input int ack_wait);
      exp_t e;
      int   n;
      n = 0;
      while (!instr_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      check({tag, " req"}, 16'(instr_req), 16'd1);
      check({tag, " addr"}, 16'(instr_addr), 16'(model_pc));
      // Stray decode control while still fetching must be ignored.
      for (int i = 0; i < ack_wait; i++) begin
         dec_valid = 1'b1; jmp_en = 1'b1; raa = 8'h5A;
         @(negedge clk);
         check({tag, " wait req"}, 16'(instr_req), 16'd1);
         check({tag, " wait addr"}, 16'(instr_addr), 16'(model_pc));
         check({tag, " wait pc"}, 16'(pc), 16'(model_pc));
      end
      clear_ctrl();
      instr_ack = 1'b1;
      @(negedge clk);
      instr_ack = 1'b0;
      check({tag, " decode req"}, 16'(instr_req), 16'd0);
      jmp_en = j; br_en = b; br_cond = c; br_offset = off; raa = r;
      {flag_z, flag_n, flag_c, flag_v} = f; halt = h; dec_valid = 1'b1;
      if (h)                    e = '{pc: model_pc, bs: 2'b00, hlt: 1'b1};
      else if (j)               e = '{pc: r, bs: 2'b10, hlt: 1'b0};
      else if (b && cond_ok(c, f)) e = '{pc: model_pc + 8'd1 + off, bs: 2'b01, hlt: 1'b0};
      else                      e = '{pc: model_pc + 8'd1, bs: 2'b00, hlt: 1'b0};
      sb.push_back(e);
      @(negedge clk);
      clear_ctrl();
      check({tag, " update bs"}, 16'(bs_sel), 16'(e.bs));
      check({tag, " update pc held"}, 16'(pc), 16'(model_pc));
      if (!h) @(negedge clk);
      e = sb.pop_front();
      check({tag, " pc"}, 16'(pc), 16'(e.pc));
      check({tag, " bs"}, 16'(bs_sel), 16'(e.bs));
      check({tag, " halted"}, 16'(halted), 16'(e.hlt));
      check({tag, " next req"}, 16'(instr_req), 16'(!e.hlt));
      model_pc = e.pc;
   endtask

   initial begin
      rst_n = 1'b0; instr_ack = 1'b0;
      clear_ctrl();
      model_pc = 8'h00;
      #12;
      check("rst pc", 16'(pc), 16'h00);
      check("rst bs", 16'(bs_sel), 16'd0);
      check("rst req", 16'(instr_req), 16'd0);
      check("rst halted", 16'(halted), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("first req", 16'(instr_req), 16'd1);

      run_instr("seq0", 0, 0, 3'd0, 8'h00, 8'h00, 4'b0000, 0, 0);
      run_instr("seq1", 0, 0, 3'd0, 8'h00, 8'h00, 4'b0000, 0, 0);
      run_instr("seq2", 0, 0, 3'd0, 8'h00, 8'h00, 4'b0000, 0, 0);
      run_instr("jmp10", 1, 0, 3'd0, 8'h00, 8'h10, 4'b0000, 0, 0);
      run_instr("jmp_br", 1, 1, 3'd0, 8'h04, 8'h80, 4'b1111, 0, 0);
      run_instr("jmp20a", 1, 0, 3'd0, 8'h00, 8'h20, 4'b0000, 0, 0);
      run_instr("brz_t", 0, 1, 3'd1, 8'hF0, 8'h00, 4'b1000, 0, 0);
      run_instr("jmp20b", 1, 0, 3'd0, 8'h00, 8'h20, 4'b0000, 0, 0);
      run_instr("brz_nt", 0, 1, 3'd1, 8'hF0, 8'h00, 4'b0000, 0, 0);
      run_instr("brn_t", 0, 1, 3'd3, 8'h05, 8'h00, 4'b0100, 0, 0);
      run_instr("br_never", 0, 1, 3'd7, 8'h10, 8'h00, 4'b1111, 0, 0);
      run_instr("brv_nt", 0, 1, 3'd6, 8'h10, 8'h00, 4'b1110, 0, 0);
      run_instr("jmpFF", 1, 0, 3'd0, 8'h00, 8'hFF, 4'b0000, 0, 0);
      run_instr("wrap_seq", 0, 0, 3'd0, 8'h00, 8'h00, 4'b0000, 0, 0);
      run_instr("jmpFE", 1, 0, 3'd0, 8'h00, 8'hFE, 4'b0000, 0, 0);
      run_instr("wrap_br", 0, 1, 3'd0, 8'h03, 8'h00, 4'b0000, 0, 0);
      run_instr("jmp01", 1, 0, 3'd0, 8'h00, 8'h01, 4'b0000, 0, 0);
      run_instr("br_neg", 0, 1, 3'd0, 8'hFC, 8'h00, 4'b0000, 0, 0);
      run_instr("ackwait", 0, 0, 3'd0, 8'h00, 8'h00, 4'b0000, 0, 4);
      run_instr("after_wait", 0, 0, 3'd0, 8'h00, 8'h00, 4'b0000, 0, 0);
      run_instr("jmp33", 1, 0, 3'd0, 8'h00, 8'h33, 4'b0000, 0, 0);
      run_instr("halt", 1, 0, 3'd0, 8'h00, 8'h77, 4'b0000, 1, 0);

      for (int i = 0; i < 5; i++) begin
         instr_ack = 1'b1; dec_valid = 1'b1; jmp_en = 1'b1; raa = 8'h44;
         @(negedge clk);
         check("halted req", 16'(instr_req), 16'd0);
         check("halted pc", 16'(pc), 16'h33);
         check("halted flag", 16'(halted), 16'd1);
      end
      instr_ack = 1'b0;
      clear_ctrl();

      #2 rst_n = 1'b0;
      #1;
      check("rst2 pc", 16'(pc), 16'h00);
      check("rst2 halted", 16'(halted), 16'd0);
      check("rst2 req", 16'(instr_req), 16'd0);
      check("rst2 bs", 16'(bs_sel), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst2 first req", 16'(instr_req), 16'd1);
      check("rst2 addr", 16'(instr_addr), 16'h00);
      model_pc = 8'h00;
      run_instr("post_rst", 0, 0, 3'd0, 8'h00, 8'h00, 4'b0000, 0, 0);

      check("sb empty", 16'(sb.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
